dir_wreq_driver: RTL
====================

# dir_wreq_driver

Stimulus-side driver for the directory write interfaces: it accepts tagged write requests from the testbench over a single push port and buffers them in an in-order FIFO. It drives them onto the four directory write channels (self dir, self tag, client dir, client tag) of the cache under test with valid/ready handshakes. It is the transmitting end of the same channels that the directory monitor samples, and together the two close the stimulus/check loop on directory state.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2.
- clock  in  1  sole clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  push request.
- in_ready  out  1  high when the FIFO can accept a push; equals !full.
- in_kind  in  2  channel select: 0 = dir, 1 = tag, 2 = clientDir, 3 = clientTag.
- in_set  in  9  set index; the client kinds use bits [6:0].
- in_way  in  3  way index.
- in_data  in  21  payload, decoded by kind:
  - dir: [0] dirty, [2:1] state, [4:3] clientStates_0, [6:5] clientStates_1, [7] prefetch.
  - tag: [18:0] tag.
  - clientDir: [1:0] data_0_state, [3:2] data_0_alias, [5:4] data_1_state, [7:6] data_1_alias.
  - clientTag: [20:0] tag.
- hold  in  1  when high, suppresses issue; the FIFO still accepts pushes.
- io_dirWReq_valid/ready  out/in  1  plus bits_set[8:0], bits_way[2:0], bits_data_dirty, bits_data_state[1:0], bits_data_clientStates_0/1[1:0], bits_data_prefetch  (all out).
- io_tagWReq_valid/ready  out/in  1  plus bits_set[8:0], bits_way[2:0], bits_tag[18:0]  (all out).
- io_clientDirWReq_valid/ready  out/in  1  plus bits_set[6:0], bits_way[2:0], bits_data_0/1_state[1:0], bits_data_0/1_alias[1:0]  (all out).
- io_clientTagWreq_valid/ready  out/in  1  plus bits_set[6:0], bits_way[2:0], bits_tag[20:0]  (all out).
- count  out  log2(DEPTH)+1  current FIFO occupancy.
- issued  out  32  number of completed channel transfers; wraps modulo 2^32.

## Operation
- The FIFO holds {kind, set, way, data} in DEPTH register entries, with wr_ptr and rd_ptr of width log2(DEPTH) that wrap naturally, plus count.
- Push fires when in_valid && in_ready. The entry is written at wr_ptr, then wr_ptr increments.
- Issue is strictly in order, from the head entry only.
  - The head drives only the channel selected by its kind. That channel's valid = !empty && !hold.
  - All other channels have valid = 0. Every bits_* field of a non-selected channel is driven 0. Payload bits that are unused for the head's kind are ignored.
- A transfer completes when the selected channel has valid && ready. Completion pops the head and increments issued.
- At most one transfer completes per cycle. No reordering: a head blocked on one channel blocks every later entry.
- Once valid is asserted, the head's fields stay stable until the transfer completes.
  - Raising hold while valid is high and ready is low withdraws valid. This is permitted because this is a testbench source.
- in_ready = (count != DEPTH). A push is refused while full, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle leave count unchanged and move both pointers.
- Reset (asynchronous, any cycle) clears:
  - count, pointers and issued to 0;
  - all channel valids and all bits_* to 0;
  - in_ready to 1 (the FIFO is empty).
  Entries pending at reset are discarded, and no partial transfer is completed.

## Timing
- Push-to-valid latency is 1 cycle. A push accepted at edge N makes the entry visible on the channel after edge N, provided it is the head, hold is low, and the FIFO was not blocked.
- There is no combinational path from in_valid to any channel output. Each channel's ready combinationally affects only the pop and the issued update at the next edge.
- Throughput is 1 transfer per cycle when ready is held high and the FIFO is non-empty.
- count, issued, in_ready and all channel outputs are functions of registered state, plus hold for the valids. They update only at clock edges, or immediately on reset assertion.
- issued wraps from 0xFFFFFFFF to 0 with no flag.

## Test plan
- Single dir push, all readies high:
  - Stimulus: kind=0, set=0x1A5, way=5, data=0x0B5.
  - Required: io_dirWReq_valid high in the next cycle only, with dirty=1, state=2, clientStates_0=2, clientStates_1=1, prefetch=1. The other three valids stay 0. issued goes 0→1 and count returns to 0.
- Backpressure:
  - Stimulus: push a tag entry (tag=0x7FFFF) then a clientTag entry (tag=0x1FFFFF). Hold io_tagWReq_ready low for 5 cycles.
  - Required: the tag fields stay stable for the 5 cycles, and io_clientTagWreq_valid stays 0 until the cycle after the tag transfer completes. The clientTag entry then issues with set bits [6:0].
- Fill:
  - Stimulus: push 8 entries with all readies low.
  - Required: count=8 and in_ready=0. A 9th push is refused even when a pop occurs in the same cycle. Draining yields the 8 entries in order, and issued=8.
- Simultaneous push and pop at count=3:
  - Required: count stays at 3, and the order is preserved across pointer wrap after 10 such cycles.
- hold:
  - Stimulus: assert hold with 2 entries queued.
  - Required: all valids are 0 and pushes are still accepted. After hold is released, transfers resume in order.
- Reset mid-drain:
  - Stimulus: drop reset_n while count=4 and a valid is asserted.
  - Required: all outputs clear immediately (valids 0, count 0, issued 0, in_ready 1), and nothing is issued after reset_n is released.

Source files
------------

// File: rtl/dir_wreq_driver.sv
// dir_wreq_driver
//
// Testbench-side source for the four directory write channels of the cache under test.
// Tagged write requests are pushed through a single port into an in-order FIFO. The head
// entry is presented on the one channel selected by its kind with a valid/ready handshake.
//
// Ports
//   clock, reset_n                 clock and asynchronous active-low reset
//   in_valid / in_ready            push handshake (in_ready = FIFO not full)
//   in_kind, in_set, in_way,       request fields; in_data is decoded per kind
//   in_data
//   hold                           suppresses issue; pushes are still accepted
//   io_dirWReq_*                   self directory write channel
//   io_tagWReq_*                   self tag write channel
//   io_clientDirWReq_*             client directory write channel
//   io_clientTagWreq_*             client tag write channel
//   count                          FIFO occupancy
//   issued                         completed transfers, wraps modulo 2^32

module dir_wreq_driver #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_kind,
    input  logic [8:0]               in_set,
    input  logic [2:0]               in_way,
    input  logic [20:0]              in_data,
    input  logic                     hold,

    output logic                     io_dirWReq_valid,
    input  logic                     io_dirWReq_ready,
    output logic [8:0]               io_dirWReq_bits_set,
    output logic [2:0]               io_dirWReq_bits_way,
    output logic                     io_dirWReq_bits_data_dirty,
    output logic [1:0]               io_dirWReq_bits_data_state,
    output logic [1:0]               io_dirWReq_bits_data_clientStates_0,
    output logic [1:0]               io_dirWReq_bits_data_clientStates_1,
    output logic                     io_dirWReq_bits_data_prefetch,

    output logic                     io_tagWReq_valid,
    input  logic                     io_tagWReq_ready,
    output logic [8:0]               io_tagWReq_bits_set,
    output logic [2:0]               io_tagWReq_bits_way,
    output logic [18:0]              io_tagWReq_bits_tag,

    output logic                     io_clientDirWReq_valid,
    input  logic                     io_clientDirWReq_ready,
    output logic [6:0]               io_clientDirWReq_bits_set,
    output logic [2:0]               io_clientDirWReq_bits_way,
    output logic [1:0]               io_clientDirWReq_bits_data_0_state,
    output logic [1:0]               io_clientDirWReq_bits_data_0_alias,
    output logic [1:0]               io_clientDirWReq_bits_data_1_state,
    output logic [1:0]               io_clientDirWReq_bits_data_1_alias,

    output logic                     io_clientTagWreq_valid,
    input  logic                     io_clientTagWreq_ready,
    output logic [6:0]               io_clientTagWreq_bits_set,
    output logic [2:0]               io_clientTagWreq_bits_way,
    output logic [20:0]              io_clientTagWreq_bits_tag,

    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              issued
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        KindDir       = 2'd0,
        KindTag       = 2'd1,
        KindClientDir = 2'd2,
        KindClientTag = 2'd3
    } kind_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [8:0]  set;
        logic [2:0]  way;
        logic [20:0] data;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_issued;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    entry_t          w_head;
    kind_e           w_head_kind;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_kind = kind_e'(w_head.kind);

    // Push is gated on !full only, so a pop in the same cycle never frees a slot early.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;

    // Only the selected channel can have valid high, so OR-ing the handshakes is exact.
    assign w_pop = (io_dirWReq_valid       && io_dirWReq_ready)       ||
                   (io_tagWReq_valid       && io_tagWReq_ready)       ||
                   (io_clientDirWReq_valid && io_clientDirWReq_ready) ||
                   (io_clientTagWreq_valid && io_clientTagWreq_ready);

    assign count  = r_count;
    assign issued = r_issued;

    // Storage carries no reset; an empty FIFO masks every entry from the outputs.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= entry_t'({in_kind, in_set, in_way, in_data});
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_issued <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_issued <= r_issued + 32'd1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Channel drive: fields follow the head, valid additionally gated by hold.
    always_comb begin
        io_dirWReq_valid                    = 1'b0;
        io_dirWReq_bits_set                 = '0;
        io_dirWReq_bits_way                 = '0;
        io_dirWReq_bits_data_dirty          = 1'b0;
        io_dirWReq_bits_data_state          = '0;
        io_dirWReq_bits_data_clientStates_0 = '0;
        io_dirWReq_bits_data_clientStates_1 = '0;
        io_dirWReq_bits_data_prefetch       = 1'b0;

        io_tagWReq_valid                    = 1'b0;
        io_tagWReq_bits_set                 = '0;
        io_tagWReq_bits_way                 = '0;
        io_tagWReq_bits_tag                 = '0;

        io_clientDirWReq_valid              = 1'b0;
        io_clientDirWReq_bits_set           = '0;
        io_clientDirWReq_bits_way           = '0;
        io_clientDirWReq_bits_data_0_state  = '0;
        io_clientDirWReq_bits_data_0_alias  = '0;
        io_clientDirWReq_bits_data_1_state  = '0;
        io_clientDirWReq_bits_data_1_alias  = '0;

        io_clientTagWreq_valid              = 1'b0;
        io_clientTagWreq_bits_set           = '0;
        io_clientTagWreq_bits_way           = '0;
        io_clientTagWreq_bits_tag           = '0;

        if (!w_empty) begin
            unique case (w_head_kind)
                KindDir: begin
                    io_dirWReq_valid                    = !hold;
                    io_dirWReq_bits_set                 = w_head.set;
                    io_dirWReq_bits_way                 = w_head.way;
                    io_dirWReq_bits_data_dirty          = w_head.data[0];
                    io_dirWReq_bits_data_state          = w_head.data[2:1];
                    io_dirWReq_bits_data_clientStates_0 = w_head.data[4:3];
                    io_dirWReq_bits_data_clientStates_1 = w_head.data[6:5];
                    io_dirWReq_bits_data_prefetch       = w_head.data[7];
                end
                KindTag: begin
                    io_tagWReq_valid    = !hold;
                    io_tagWReq_bits_set = w_head.set;
                    io_tagWReq_bits_way = w_head.way;
                    io_tagWReq_bits_tag = w_head.data[18:0];
                end
                KindClientDir: begin
                    io_clientDirWReq_valid             = !hold;
                    io_clientDirWReq_bits_set          = w_head.set[6:0];
                    io_clientDirWReq_bits_way          = w_head.way;
                    io_clientDirWReq_bits_data_0_state = w_head.data[1:0];
                    io_clientDirWReq_bits_data_0_alias = w_head.data[3:2];
                    io_clientDirWReq_bits_data_1_state = w_head.data[5:4];
                    io_clientDirWReq_bits_data_1_alias = w_head.data[7:6];
                end
                KindClientTag: begin
                    io_clientTagWreq_valid    = !hold;
                    io_clientTagWreq_bits_set = w_head.set[6:0];
                    io_clientTagWreq_bits_way = w_head.way;
                    io_clientTagWreq_bits_tag = w_head.data;
                end
                default: ;
            endcase
        end
    end

endmodule
